// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state encoding and the requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  function automatic logic is_data(
    input logic id
  );
    return id == REQ_D;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_RR_EN: alternate on contention, else data beats fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic win
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    win = REQ_IF;
    unique case (1'b1)
      (if_req && d_req):  win = ~last_grant;
      (d_req && !if_req): win = REQ_D;
      default:            win = REQ_IF;
    endcase
  end
`else
  logic unused_in;
  assign unused_in = last_grant | if_req;

  always_comb begin
    win = REQ_IF;
    if (d_req) win = REQ_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store paths.
// Build with MEM_ARB_RR_EN for round-robin on contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q;
  logic              win_d;
  logic              win_q;
  logic              last_grant;
  logic              grant;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_valid_q;
  logic              d_valid_q;
  logic              busy_q;

  assign grant = (state_q == IDLE) && (if_req || d_req);

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .win        (win_d)
  );

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ_IF;
    end else if (grant) begin
      last_grant_q <= win_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = REQ_IF;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      win_q       <= REQ_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q   <= BUSY;
            win_q     <= win_d;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            if (is_data(win_d)) begin
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            // valid rises with RESP so it lasts exactly that cycle
            if (is_data(win_q)) begin
              d_valid_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= mem_rdata;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter.
// Memory responder plus a transaction-level order/data model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  bit          mem_auto;
  int          ack_wait;
  int          wcnt;
  int          cur_wait;
  bit          in_txn;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;
  bit          m_last;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return init_word(a);
  endfunction

  // memory model: acks after cur_wait BUSY cycles
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    wcnt = 0;
    cur_wait = 0;
    in_txn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          in_txn = 1'b0;
        end else if (mem_req) begin
          if (!in_txn) begin
            in_txn = 1'b1;
            wcnt = 0;
            cur_wait = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
          end
          if (wcnt >= cur_wait) begin
            mem_ack = 1'b1;
            if (mem_we) begin
              mem_arr[mem_addr] = mem_wdata;
              mem_rdata = $urandom;
            end else if (mem_arr.exists(mem_addr)) begin
              mem_rdata = mem_arr[mem_addr];
            end else begin
              mem_rdata = init_word(mem_addr);
            end
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b required 0", mem_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_if_valid: got %b required 0", if_valid); end
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rst_d_valid: got %b required 0", d_valid); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
    tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
    tests++; if (if_rdata !== 32'h0) begin fails++; $display("FAIL rst_if_rdata: got %h required 0", if_rdata); end
    tests++; if (d_rdata !== 32'h0) begin fails++; $display("FAIL rst_d_rdata: got %h required 0", d_rdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy_idle: got %b required 0", busy); end
  endtask

  task automatic test_fetch;
    int lat;
    bit seen_we;
    bit busy1;
    mem_arr[32'h40] = 32'h8C220004;
    exp_mem[32'h40] = 32'h8C220004;
    ack_wait = 0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h40;
    lat = 0;
    seen_we = 1'b0;
    busy1 = 1'b0;
    while (!if_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_we) seen_we = 1'b1;
      if (lat == 1) busy1 = busy;
    end
    if_req = 1'b0;
    tests++; if (lat !== 2) begin fails++; $display("FAIL fetch_latency: got %0d required 2", lat); end
    tests++; if (if_rdata !== 32'h8C220004) begin fails++; $display("FAIL fetch_rdata: got %h required 8c220004", if_rdata); end
    tests++; if (seen_we !== 1'b0) begin fails++; $display("FAIL fetch_we: got %b required 0", seen_we); end
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL fetch_busy: got %b required 1", busy1); end
    m_irdata = 32'h8C220004;
    m_last = 1'b0;
    @(negedge clk);
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL fetch_pulse: got %b required 0", if_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fetch_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_store;
    int cyc;
    int lat;
    int pulses;
    int req_cycles;
    ack_wait = 3;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h100;
    d_wdata = 32'hDEADBEEF;
    lat = 0;
    pulses = 0;
    req_cycles = 0;
    for (cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL store_we: got %b required 1", mem_we); end
        tests++; if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL store_wdata: got %h required deadbeef", mem_wdata); end
        tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL store_addr: got %h required 100", mem_addr); end
      end
      if (d_valid) begin
        pulses++;
        if (lat == 0) lat = cyc;
        d_req = 1'b0;
        d_we = 1'b0;
      end
    end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL store_pulses: got %0d required 1", pulses); end
    tests++; if (lat !== 5) begin fails++; $display("FAIL store_latency: got %0d required 5", lat); end
    tests++; if (req_cycles !== 4) begin fails++; $display("FAIL store_busy_cycles: got %0d required 4", req_cycles); end
    tests++; if (d_rdata !== m_drdata) begin fails++; $display("FAIL store_rdata: got %h required %h", d_rdata, m_drdata); end
    exp_mem[32'h100] = 32'hDEADBEEF;
    m_last = 1'b1;
  endtask

  task automatic test_ack_idle;
    mem_auto = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ackidle_busy: got %b required 0", busy); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL ackidle_req: got %b required 0", mem_req); end
    tests++; if ({if_valid, d_valid} !== 2'b00) begin fails++; $display("FAIL ackidle_valid: got %b required 00", {if_valid, d_valid}); end
    @(negedge clk);
    tests++; if (if_rdata !== m_irdata) begin fails++; $display("FAIL ackidle_irdata: got %h required %h", if_rdata, m_irdata); end
    tests++; if (d_rdata !== m_drdata) begin fails++; $display("FAIL ackidle_drdata: got %h required %h", d_rdata, m_drdata); end
    tests++; if ({busy, if_valid, d_valid} !== 3'b000) begin fails++; $display("FAIL ackidle_after: got %b required 000", {busy, if_valid, d_valid}); end
    mem_auto = 1'b1;
  endtask

  task automatic run_pair(
    input bit          do_f,
    input bit          do_d,
    input logic [31:0] fa,
    input logic        dwe,
    input logic [31:0] da,
    input logic [31:0] dw
  );
    bit first_d;
    bit f_done;
    bit d_done;
    bit cur_d;
    int cyc;
`ifdef MEM_ARB_RR_EN
    first_d = (do_f && do_d) ? !m_last : do_d;
`else
    first_d = do_d;
`endif
    @(negedge clk);
    if_req = do_f;
    if_addr = fa;
    d_req = do_d;
    d_we = dwe;
    d_addr = da;
    d_wdata = dw;
    f_done = !do_f;
    d_done = !do_d;
    cyc = 0;
    while (!(f_done && d_done) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      cur_d = first_d ? !d_done : f_done;
      tests++; if ((if_valid && d_valid) !== 1'b0) begin fails++; $display("FAIL both_valid: got 1 required 0"); end
      if (mem_req) begin
        tests++; if (mem_addr !== (cur_d ? da : fa)) begin fails++; $display("FAIL pair_addr: got %h required %h", mem_addr, cur_d ? da : fa); end
        tests++; if (mem_we !== (cur_d && dwe)) begin fails++; $display("FAIL pair_we: got %b required %b", mem_we, cur_d && dwe); end
        if (cur_d && dwe) begin
          tests++; if (mem_wdata !== dw) begin fails++; $display("FAIL pair_wdata: got %h required %h", mem_wdata, dw); end
        end
      end
      if (d_valid) begin
        tests++; if (cur_d !== 1'b1) begin fails++; $display("FAIL order_d: got data required fetch"); end
        if (!dwe) m_drdata = exp_rd(da);
        tests++; if (d_rdata !== m_drdata) begin fails++; $display("FAIL pair_drdata: got %h required %h", d_rdata, m_drdata); end
        if (dwe) exp_mem[da] = dw;
        d_done = 1'b1;
        d_req = 1'b0;
        m_last = 1'b1;
      end
      if (if_valid) begin
        tests++; if (cur_d !== 1'b0) begin fails++; $display("FAIL order_f: got fetch required data"); end
        m_irdata = exp_rd(fa);
        tests++; if (if_rdata !== m_irdata) begin fails++; $display("FAIL pair_irdata: got %h required %h", if_rdata, m_irdata); end
        f_done = 1'b1;
        if_req = 1'b0;
        m_last = 1'b0;
      end
    end
    tests++; if (!(f_done && d_done)) begin fails++; $display("FAIL pair_timeout: got %b%b required 11", f_done, d_done); end
    @(negedge clk);
    tests++; if ({if_valid, d_valid} !== 2'b00) begin fails++; $display("FAIL pair_pulse: got %b required 00", {if_valid, d_valid}); end
  endtask

  task automatic test_contention;
    ack_wait = -1;
    run_pair(1'b1, 1'b1, 32'h200, 1'b0, 32'h300, 32'h0);
    run_pair(1'b1, 1'b1, 32'h204, 1'b0, 32'h100, 32'h0);
    run_pair(1'b0, 1'b1, 32'h0, 1'b1, 32'h308, 32'h12345678);
    run_pair(1'b1, 1'b1, 32'h308, 1'b0, 32'h308, 32'h0);
  endtask

  task automatic test_random;
    int r;
    ack_wait = -1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(1, 3));
      run_pair(r[0], r[1],
               {26'h0, 4'($urandom_range(0, 15)), 2'b00},
               1'($urandom),
               {26'h0, 4'($urandom_range(0, 15)), 2'b00},
               $urandom);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    mem_auto = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h80;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL midrst_busy: got %b required 1", mem_req); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL midrst_req: got %b required 0", mem_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busyo: got %b required 0", busy); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL midrst_addr: got %h required 0", mem_addr); end
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    m_irdata = '0;
    m_drdata = '0;
    m_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      tests++; if ({busy, if_valid, d_valid} !== 3'b000) begin fails++; $display("FAIL midrst_quiet: got %b required 000", {busy, if_valid, d_valid}); end
    end
    tests++; if (if_rdata !== 32'h0) begin fails++; $display("FAIL midrst_irdata: got %h required 0", if_rdata); end
    mem_auto = 1'b1;
    ack_wait = 1;
    run_pair(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    mem_auto = 1'b1;
    ack_wait = 0;
    m_irdata = '0;
    m_drdata = '0;
    m_last = 1'b0;
    test_reset;
    test_fetch;
    test_store;
    test_ack_idle;
    test_contention;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
